ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter that shares the single-port 256x16 synchronous RAM between two requesters: port 0 is the CPU memory interface, port 1 is the debug/loader interface. It accepts one read or write per grant and drives the RAM address, data and write strobe. It returns read data with a valid pulse, so memory can be preloaded or inspected while the CPU runs.

## Interface
- AW, 8: address width (RAM depth 2^AW words)
- DW, 16: data width
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (port 0 always wins ties)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req0, req1  input  1  access request, held until gnt seen
- we0, we1  input  1  1 = write, 0 = read; valid while req high
- addr0, addr1  input  AW  word address; valid while req high
- wdata0, wdata1  input  DW  write data; valid while req high
- gnt0, gnt1  output  1  one-cycle grant pulse; request operands captured
- rvalid0, rvalid1  output  1  one-cycle completion pulse, for reads and writes
- rdata0, rdata1  output  DW  read data, valid when rvalid high; held otherwise
- ram_addr  output  AW  RAM address
- ram_din  output  DW  RAM write data
- ram_write  output  1  RAM write enable, one cycle per write
- ram_dout  input  DW  RAM read data; valid the cycle after ram_addr is sampled

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- Arbitration happens only in IDLE and RESP, and only when req0 or req1 is high.
  - If one request is pending, it wins.
  - If both are pending and PRIO_MODE=0, the port not granted most recently wins.
  - If both are pending and PRIO_MODE=1, port 0 wins.
- On arbitration, at the edge:
  - Latch the winner's addr into ram_addr and wdata into ram_din.
  - Set ram_write to the winner's we.
  - Set the winner's gnt.
  - Record the winner in the owner and last_grant registers.
  - Go to ACCESS.
- With no request, IDLE stays in IDLE and RESP goes to IDLE.
- ACCESS: the RAM samples ram_addr and ram_write at the closing edge. That edge clears ram_write and gnt, and the FSM goes to RESP.
- RESP: ram_dout holds the read result. At the closing edge:
  - The owner's rvalid is set.
  - On a read, the owner's rdata is loaded from ram_dout.
  - On a write, rdata is unchanged.
  - Arbitration runs as above.
- A requester may drop req, or change its operands, from the edge at which it sees gnt high. A req still high, or raised again, in RESP counts as a new request.
- Only the owner's rdata register updates. The other port's rdata is untouched.
- ram_addr and ram_din hold their last values outside ACCESS. ram_write is high only in ACCESS cycles for writes.

## Timing
- Reset values:
  - state = IDLE, last_grant = port 1 (so port 0 wins the first tie).
  - gnt0/1, rvalid0/1, ram_write = 0.
  - ram_addr, ram_din, rdata0/1 = 0.
- Single access, request first seen at edge E:
  - gnt is high in the cycle after E.
  - ram_write is high in the same cycle, for a write.
  - rvalid and rdata are valid two cycles after E's cycle, i.e. 3 cycles from req sampled to rvalid.
- Back-to-back throughput: one access per 2 cycles. RESP chains directly into ACCESS, and the rvalid of access N overlaps the gnt of access N+1.
- Both ports continuously requesting, PRIO_MODE=0: grants strictly alternate 0,1,0,1.
- Both ports continuously requesting, PRIO_MODE=1: port 0 takes every grant and port 1 starves (intended).
- Simultaneous new req and pending rvalid on the same port: both are legal. rvalid belongs to the previous access.
- Reset asserted mid-operation, in ACCESS or RESP:
  - ram_write drops immediately.
  - The in-flight access is abandoned; no gnt or rvalid follows.
  - A write already sampled by the RAM before reset stays written.
- Address wrap: none; addresses are used as given (AW bits).

## Test plan
- Reset: assert rst mid-write (ram_write=1) -> ram_write and all gnt/rvalid go 0 asynchronously; after release, FSM is in IDLE with all outputs 0.
- Port 0 single write then read: write addr0=8'h10, wdata0=16'h1234 -> gnt0 one cycle later with ram_write=1, ram_addr=8'h10; then read 8'h10 -> rvalid0 3 cycles after req, rdata0=16'h1234, rdata1 unchanged.
- Tie, PRIO_MODE=0: req0 and req1 both raised the cycle after reset and held, port 0 reading addr 8'h01, port 1 reading addr 8'h02 -> grants in order 0,1,0,1; each grant 2 cycles apart; rdata0 = mem[8'h01], rdata1 = mem[8'h02].
- Tie, PRIO_MODE=1: both ports hold req for 10 cycles -> only gnt0 pulses (5 times); gnt1 fires on the first arbitration after req0 drops.
- Cross-port coherence: port 1 writes 8'hFF=16'hBEEF, then port 0 reads 8'hFF -> rdata0=16'hBEEF; the address-8'hFF boundary is accessed with no wrap artefacts.
- Re-request on grant: port 0 holds req through gnt0 with a new addr -> treated as a second request in RESP, gnt0 pulses again 2 cycles after the first, and one rvalid0 is returned per grant.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_write;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_din, ram_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_din, ram_write
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port RAM between a CPU port (0) and a debug/loader port (1).
// One access per grant; every output is registered.
module ram_arbiter #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 16,
    parameter int unsigned PRIO_MODE = 0
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e state_q, state_d;

    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic          op_we_q, op_we_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_write_q, ram_write_d;

    logic          arb;
    logic          winner;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Arbitration is only legal in the two states that can launch an access.
    always_comb begin
        arb = ((state_q == StIdle) || (state_q == StResp)) && (bus.req0 || bus.req1);
        if (bus.req0 && bus.req1) begin
            winner = (PRIO_MODE != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            winner = bus.req1;
        end
        win_we    = winner ? bus.we1    : bus.we0;
        win_addr  = winner ? bus.addr1  : bus.addr0;
        win_wdata = winner ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = arb ? StAccess : StIdle;
            StAccess: state_d = StResp;
            StResp:   state_d = arb ? StAccess : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_we_d      = op_we_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_write_d  = 1'b0;

        // Completion of the previous access; ram_dout holds its read result now.
        if (state_q == StResp) begin
            if (owner_q) begin
                rvalid1_d = 1'b1;
                if (!op_we_q) rdata1_d = bus.ram_dout;
            end else begin
                rvalid0_d = 1'b1;
                if (!op_we_q) rdata0_d = bus.ram_dout;
            end
        end

        if (arb) begin
            ram_addr_d   = win_addr;
            ram_din_d    = win_wdata;
            ram_write_d  = win_we;
            op_we_d      = win_we;
            owner_d      = winner;
            last_grant_d = winner;
            gnt0_d       = ~winner;
            gnt1_d       = winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_we_q      <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_write_q  <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_we_q      <= op_we_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_write_q  <= ram_write_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_write = ram_write_q;

    a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt0_q && gnt1_q));
    a_rvalid_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(rvalid0_q && rvalid1_q));
    a_write_in_access: assert property (@(posedge clk) disable iff (rst)
        ram_write_q |-> (state_q == StAccess));

endmodule
